// File: rtl/cache_arb_pkg.sv
// Shared state type and round-robin helpers for the cache request arbiter.
package cache_arb_pkg;

  localparam int MAX_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // One-hot grant for the first valid requester after ptr, wrapping over num requesters.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0]   ptr,
                                                 input logic [2:0]         num);
    logic [MAX_REQ-1:0] grant;
    logic [2:0]         idx;
    logic               found;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = 3'(ptr) + 3'(k);
      if (idx >= num) begin
        idx = idx - num;
      end
      if (!found && (3'(k) <= num) && valid[idx[1:0]]) begin
        grant[idx[1:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick with a registered last-winner pointer.
module rr_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_update,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic [IDX_W-1:0]   r_ptr;
  logic [MAX_REQ-1:0] w_valid_pad;
  logic [MAX_REQ-1:0] w_grant_pad;

  // Pad the request vector to the helper width so one function serves every NUM_REQ.
  always_comb begin
    w_valid_pad                = '0;
    w_valid_pad[NUM_REQ-1:0]   = i_valid;
    w_grant_pad                = rr_pick(w_valid_pad, r_ptr, 3'(NUM_REQ));
  end

  assign o_grant     = w_grant_pad[NUM_REQ-1:0];
  assign o_grant_idx = oh_to_idx(w_grant_pad);

  // Pointer starts at the last requester so requester 0 wins first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (i_update) begin
      r_ptr <= o_grant_idx;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares one cache read/write port between NUM_REQ requesters, one access at a time,
// returning the cache response to the winner and counting hits and misses.
module cache_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_LAT  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_hit,
  output logic                          rsp_miss,
  output logic [ADDR_WIDTH-1:0]         cache_addr,
  output logic [DATA_WIDTH-1:0]         cache_write_data,
  output logic                          cache_read,
  output logic                          cache_write,
  input  logic [DATA_WIDTH-1:0]         cache_read_data,
  input  logic                          cache_hit,
  input  logic                          cache_miss,
  output logic [CNT_WIDTH-1:0]          hit_cnt,
  output logic [CNT_WIDTH-1:0]          miss_cnt
);

  arb_state_t             r_state;
  logic [2:0]             r_lat_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_REQ-1:0]     w_grant;
  logic [IDX_W-1:0]       w_grant_idx;
  logic                   w_accept;
  logic                   w_sel_write;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk         (clk),
    .rst         (reset),
    .i_valid     (req_valid),
    .i_update    (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // Grant is offered only in IDLE; it follows valid combinationally so a withdrawn request is never granted.
  assign w_accept  = (r_state == IDLE) && (|w_grant);
  assign req_ready = ((r_state == IDLE) && !reset) ? w_grant : '0;

  // The grant is one-hot, so an AND-OR mux selects the winner's fields.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_write = w_sel_write | (req_write[i] & w_grant[i]);
      w_sel_addr  = w_sel_addr  | (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{w_grant[i]}});
      w_sel_wdata = w_sel_wdata | (req_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_grant[i]}});
    end
  end

  // Access sequencer: issue one cache cycle, wait out the latency, return one response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_lat_cnt        <= 3'd0;
      r_idx            <= '0;
      rsp_valid        <= '0;
      rsp_rdata        <= '0;
      rsp_hit          <= 1'b0;
      rsp_miss         <= 1'b0;
      cache_addr       <= '0;
      cache_write_data <= '0;
      cache_read       <= 1'b0;
      cache_write      <= 1'b0;
      hit_cnt          <= '0;
      miss_cnt         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            cache_addr       <= w_sel_addr;
            cache_write_data <= w_sel_wdata;
            cache_read       <= !w_sel_write;
            cache_write      <= w_sel_write;
            r_idx            <= w_grant_idx;
            r_state          <= ISSUE;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          cache_read  <= 1'b0;
          cache_write <= 1'b0;
          r_lat_cnt   <= 3'(CACHE_LAT);
          r_state     <= WAIT;
        end
        WAIT: begin
          if (r_lat_cnt == 3'd0) begin
            rsp_rdata <= cache_read_data;
            rsp_hit   <= cache_hit;
            rsp_miss  <= cache_miss;
            for (int i = 0; i < NUM_REQ; i++) begin
              rsp_valid[i] <= (r_idx == IDX_W'(i));
            end
            r_state <= RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          if (rsp_hit && (hit_cnt != {CNT_WIDTH{1'b1}})) begin
            hit_cnt <= hit_cnt + CNT_WIDTH'(1);
          end
          if (rsp_miss && (miss_cnt != {CNT_WIDTH{1'b1}})) begin
            miss_cnt <= miss_cnt + CNT_WIDTH'(1);
          end
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: behavioural cache, directed scenarios and randomized traffic
// checked against a round-robin / cache-semantics reference model.
module tb_cache_req_arbiter;

  localparam int NR = 2, AW = 32, DW = 32, LAT = 1, CW = 4;

  logic clk = 1'b0;
  logic reset, cache_clr;
  logic [NR-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, cache_write_data, cache_read_data;
  logic             rsp_hit, rsp_miss, cache_read, cache_write, cache_hit, cache_miss;
  logic [AW-1:0]    cache_addr;
  logic [CW-1:0]    hit_cnt, miss_cnt;
  int n_cmp = 0, n_fail = 0;
  int grant_log[$];

  logic          c_pres [16];
  logic          c_wr   [16];
  logic [DW-1:0] c_mem  [16];
  logic [3:0]    c_idx;

  always #5 clk = ~clk;

  cache_req_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_LAT(LAT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_hit(rsp_hit), .rsp_miss(rsp_miss), .cache_addr(cache_addr), .cache_write_data(cache_write_data),
    .cache_read(cache_read), .cache_write(cache_write), .cache_read_data(cache_read_data),
    .cache_hit(cache_hit), .cache_miss(cache_miss), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  function automatic logic [31:0] backing(input logic [3:0] a);
    return 32'hA500_0000 | {28'd0, a};
  endfunction

  // Behavioural 16-entry cache: samples read/write at the edge, outputs valid one cycle later and held.
  assign c_idx = cache_addr[3:0];
  always @(posedge clk) begin
    if (cache_clr) begin
      for (int i = 0; i < 16; i++) begin c_pres[i] <= 1'b0; c_wr[i] <= 1'b0; c_mem[i] <= '0; end
      cache_hit <= 1'b0; cache_miss <= 1'b0; cache_read_data <= '0;
    end else if (cache_read || cache_write) begin
      cache_hit  <= c_pres[c_idx];
      cache_miss <= !c_pres[c_idx];
      c_pres[c_idx] <= 1'b1;
      if (cache_write) begin
        c_mem[c_idx] <= cache_write_data; c_wr[c_idx] <= 1'b1; cache_read_data <= 32'hDEAD_BEEF;
      end else begin
        cache_read_data <= c_wr[c_idx] ? c_mem[c_idx] : backing(c_idx);
      end
    end
  end

  task automatic do_reset(input bit clr);
    @(negedge clk);
    reset = 1'b1; cache_clr = clr; req_valid = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; cache_clr = 1'b0;
  endtask

  // Drives one request from 'who' and observes the whole transaction; returns at the cycle after RESP.
  task automatic issue_one(input int who, input bit wr, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [NR-1:0] rv, output logic h, output logic m,
                           output logic [31:0] rd, output int pulses, output logic [31:0] seen_addr);
    bit acc;
    lat = -1; rv = '0; h = 1'b0; m = 1'b0; rd = '0; pulses = 0; seen_addr = '0; acc = 1'b0;
    @(negedge clk);
    req_valid = '0; req_valid[who] = 1'b1; req_write[who] = wr;
    req_addr[who*AW +: AW] = a; req_wdata[who*DW +: DW] = d;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready[who]) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    if (acc) begin
      @(negedge clk);
      req_valid = '0;
      for (int c = 1; c <= 20; c++) begin
        if (cache_read || cache_write) begin pulses++; seen_addr = cache_addr; end
        if (rsp_valid != '0) begin lat = c; rv = rsp_valid; h = rsp_hit; m = rsp_miss; rd = rsp_rdata; break; end
        @(negedge clk);
      end
      @(negedge clk);
    end else begin
      req_valid = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cache_clr = 1'b1; req_valid = '1; req_write = '0; req_addr = '0; req_wdata = '0;
    #50;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_hit, rsp_miss, cache_addr, cache_write_data,
         cache_read, cache_write, hit_cnt, miss_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: ready=%b rsp_valid=%b rd=%b wr=%b hit_cnt=%0d miss_cnt=%0d want all 0",
                         req_ready, rsp_valid, cache_read, cache_write, hit_cnt, miss_cnt);
    end
    @(negedge clk);
    reset = 1'b0; cache_clr = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL reset_first_grant: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_cold_read();
    int lat, p; logic [NR-1:0] rv; logic h, m; logic [31:0] rd, sa;
    do_reset(1'b1);
    issue_one(0, 1'b0, 32'hC, 32'h0, lat, rv, h, m, rd, p, sa);
    n_cmp++; if (p != 1)          begin n_fail++; $display("FAIL cold_read_pulses: got %0d want 1", p); end
    n_cmp++; if (sa !== 32'hC)    begin n_fail++; $display("FAIL cold_read_addr: got %h want c", sa); end
    n_cmp++; if (lat != 3 + LAT)  begin n_fail++; $display("FAIL cold_read_latency: got %0d want %0d", lat, 3 + LAT); end
    n_cmp++; if (rv !== 2'b01)    begin n_fail++; $display("FAIL cold_read_rsp_valid: got %b want 01", rv); end
    n_cmp++; if ({h, m} !== 2'b01) begin n_fail++; $display("FAIL cold_read_hitmiss: got %b want 01", {h, m}); end
    n_cmp++; if (rd !== backing(4'hC)) begin n_fail++; $display("FAIL cold_read_rdata: got %h want %h", rd, backing(4'hC)); end
    n_cmp++; if (miss_cnt !== 4'd1 || hit_cnt !== 4'd0) begin
      n_fail++; $display("FAIL cold_read_counters: got hit=%0d miss=%0d want 0/1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_write_then_read();
    int lat, p; logic [NR-1:0] rv; logic h, m; logic [31:0] rd, sa;
    issue_one(1, 1'b1, 32'hD, 32'hBABECAFE, lat, rv, h, m, rd, p, sa);
    n_cmp++; if (rv !== 2'b10 || lat != 3 + LAT) begin
      n_fail++; $display("FAIL write_rsp: got rv=%b lat=%0d want 10/%0d", rv, lat, 3 + LAT); end
    issue_one(0, 1'b0, 32'hD, 32'h0, lat, rv, h, m, rd, p, sa);
    n_cmp++; if ({h, m} !== 2'b10)   begin n_fail++; $display("FAIL wr_rd_hitmiss: got %b want 10", {h, m}); end
    n_cmp++; if (rd !== 32'hBABECAFE) begin n_fail++; $display("FAIL wr_rd_rdata: got %h want babecafe", rd); end
    n_cmp++; if (hit_cnt !== 4'd1 || miss_cnt !== 4'd2) begin
      n_fail++; $display("FAIL wr_rd_counters: got hit=%0d miss=%0d want 1/2", hit_cnt, miss_cnt); end
  endtask

  task automatic test_reset_in_wait();
    int seen, bad;
    @(negedge clk);
    req_valid = 2'b01; req_write = '0; req_addr[0 +: AW] = 32'h3;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_wait_grant: got %b want 01", req_ready); end
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    #2; reset = 1'b1; #1;
    n_cmp++;
    if ({cache_read, cache_write, rsp_valid, req_ready, hit_cnt, miss_cnt} !== '0) begin
      n_fail++; $display("FAIL rst_wait_outputs: rd=%b wr=%b rsp=%b ready=%b want 0", cache_read, cache_write, rsp_valid, req_ready);
    end
    seen = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid != '0) seen++; end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rst_wait_no_rsp: got %0d pulses want 0", seen); end
    req_valid = 2'b11; req_addr[0 +: AW] = 32'h3; req_addr[AW +: AW] = 32'h4;
    reset = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_wait_regrant: got %b want 01", req_ready); end
    @(negedge clk); req_valid = '0;
    seen = 0; bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid == 2'b01) seen++; else if (rsp_valid != '0) bad++;
    end
    n_cmp++; if (seen != 1 || bad != 0) begin
      n_fail++; $display("FAIL rst_wait_after: got %0d good %0d stray pulses want 1/0", seen, bad); end
  endtask

  // Randomized traffic checked cycle by cycle against the round-robin and cache reference model.
  task automatic run_traffic(input string name, input int n_each, input bit sparse,
                             input logic [31:0] amask, input int max_cyc);
    bit pend[NR]; int left[NR];
    bit rp[16]; bit rw[16]; logic [31:0] rm[16];
    int ptr, since, win, cyc, hits, misses;
    bit exp_wr, exp_h, done;
    logic [31:0] exp_a, exp_d, exp_rd;
    logic [3:0] a4;
    logic [NR-1:0] exp_ready, exp_rv;
    do_reset(1'b1);
    grant_log.delete();
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; left[i] = n_each; end
    for (int i = 0; i < 16; i++) begin rp[i] = 1'b0; rw[i] = 1'b0; rm[i] = '0; end
    ptr = NR - 1; since = 99; hits = 0; misses = 0; cyc = 0; win = 0;
    exp_wr = 1'b0; exp_h = 1'b0; exp_a = '0; exp_d = '0; exp_rd = '0; done = 1'b0;
    while (cyc < max_cyc) begin
      @(negedge clk); cyc++;
      if (since < 99) since++;
      n_cmp++; if (cache_read && cache_write) begin n_fail++; $display("FAIL %s_rw_both: got 11 want not both", name); end
      if (since == 1) begin
        n_cmp++;
        if (cache_read !== !exp_wr || cache_write !== exp_wr || cache_addr !== exp_a ||
            (exp_wr && cache_write_data !== exp_d)) begin
          n_fail++; $display("FAIL %s_issue: got rd=%b wr=%b addr=%h wdata=%h want wr=%b addr=%h wdata=%h",
                             name, cache_read, cache_write, cache_addr, cache_write_data, exp_wr, exp_a, exp_d);
        end
      end
      exp_rv = '0; if (since == 4) exp_rv[win] = 1'b1;
      n_cmp++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL %s_rsp_valid: got %b want %b", name, rsp_valid, exp_rv); end
      if (since == 4) begin
        n_cmp++;
        if (rsp_hit !== exp_h || rsp_miss !== !exp_h || (!exp_wr && rsp_rdata !== exp_rd)) begin
          n_fail++; $display("FAIL %s_rsp_data: got hit=%b miss=%b rdata=%h want hit=%b rdata=%h",
                             name, rsp_hit, rsp_miss, rsp_rdata, exp_h, exp_rd);
        end
      end
      if (since == 5) begin
        if (exp_h) hits = (hits < 15) ? hits + 1 : 15; else misses = (misses < 15) ? misses + 1 : 15;
        n_cmp++;
        if (hit_cnt !== CW'(hits) || miss_cnt !== CW'(misses)) begin
          n_fail++; $display("FAIL %s_counters: got %0d/%0d want %0d/%0d", name, hit_cnt, miss_cnt, hits, misses);
        end
      end
      done = (since >= 5);
      for (int i = 0; i < NR; i++) if (left[i] != 0 || pend[i]) done = 1'b0;
      if (done) break;
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && left[i] > 0 && (!sparse || $urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1; left[i]--;
          req_write[i] = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW] = $urandom() & amask;
          req_wdata[i*DW +: DW] = $urandom();
        end else if (pend[i] && sparse && $urandom_range(0, 7) == 0) begin
          pend[i] = 1'b0;
        end
        req_valid[i] = pend[i];
      end
      #1;
      win = -1;
      if (since >= 5) begin
        for (int k = 1; k <= NR; k++) if (win < 0 && pend[(ptr + k) % NR]) win = (ptr + k) % NR;
      end
      exp_ready = '0; if (win >= 0) exp_ready[win] = 1'b1;
      n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL %s_ready: got %b want %b", name, req_ready, exp_ready); end
      if (win >= 0) begin
        ptr = win; since = 0; pend[win] = 1'b0; grant_log.push_back(win);
        exp_wr = req_write[win]; exp_a = req_addr[win*AW +: AW]; exp_d = req_wdata[win*DW +: DW];
        a4 = exp_a[3:0];
        exp_h  = rp[a4];
        exp_rd = rw[a4] ? rm[a4] : backing(a4);
        if (exp_wr) begin rm[a4] = exp_d; rw[a4] = 1'b1; end
        rp[a4] = 1'b1;
      end else begin
        win = (since < 99) ? win : 0;
      end
      if (since != 0 && win < 0) win = (grant_log.size() > 0) ? grant_log[grant_log.size() - 1] : 0;
    end
    n_cmp++; if (cyc >= max_cyc) begin n_fail++; $display("FAIL %s_timeout: got %0d cycles want < %0d", name, cyc, max_cyc); end
    req_valid = '0;
  endtask

  task automatic test_fairness();
    run_traffic("fair", 6, 1'b0, 32'hF, 1000);
    n_cmp++; if (grant_log.size() != 12) begin n_fail++; $display("FAIL fair_count: got %0d want 12", grant_log.size()); end
    for (int k = 0; k < grant_log.size(); k++) begin
      n_cmp++; if (grant_log[k] != k % 2) begin n_fail++; $display("FAIL fair_order[%0d]: got %0d want %0d", k, grant_log[k], k % 2); end
    end
  endtask

  task automatic test_random();
    run_traffic("rand", 15, 1'b1, 32'hF, 3000);
  endtask

  task automatic test_saturation();
    run_traffic("sat", 12, 1'b0, 32'h0, 1000);
    n_cmp++; if (hit_cnt !== 4'hF)  begin n_fail++; $display("FAIL sat_hit_cnt: got %0d want 15", hit_cnt); end
    n_cmp++; if (miss_cnt !== 4'h1) begin n_fail++; $display("FAIL sat_miss_cnt: got %0d want 1", miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_then_read();
    test_reset_in_wait();
    test_fairness();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
